// File: rtl/irrigation_valve_ctrl.sv
// rtl/irrigation_valve_ctrl.sv - timed valve/pump driver with rain inhibit, abort and cooldown
// Optional usage accumulator on total_on_s is built only when IRRIG_USAGE_LOG_EN is defined.
module irrigation_valve_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int MAX_ON_S      = 60,
    parameter int MIN_OFF_S     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  irrigation_time,
    input  logic        rain_present,
    input  logic        start,
    input  logic        abort,
    output logic        ready,
    output logic        valve_on,
    output logic        busy,
    output logic [7:0]  remaining_s,
    output logic        done,
    output logic [1:0]  status,
    output logic [15:0] total_on_s
);

    localparam int              PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICKS_PER_SEC - 1);
    localparam int              CD_CYCLES = MIN_OFF_S * TICKS_PER_SEC;
    localparam int              CW        = (CD_CYCLES > 1) ? $clog2(CD_CYCLES) : 1;
    localparam logic [CW-1:0]   CD_MAX    = CW'((CD_CYCLES > 0) ? CD_CYCLES - 1 : 0);
    localparam logic [7:0]      MAX_ON    = 8'(MAX_ON_S);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_COOLDOWN
    } state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [CW-1:0]   cd_cnt;
    logic            sec_wrap;
    logic            run_stop;
    logic [7:0]      req_clamped;

    assign ready       = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign sec_wrap    = (state == S_RUN) && (presc == PRESC_MAX);
    assign run_stop    = abort || rain_present;
    assign req_clamped = (irrigation_time > MAX_ON) ? MAX_ON : irrigation_time;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            presc       <= '0;
            cd_cnt      <= '0;
            valve_on    <= 1'b0;
            remaining_s <= 8'd0;
            done        <= 1'b0;
            status      <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort on the same edge as start swallows the command entirely
                    if (start && !abort) begin
                        if (rain_present) begin
                            done   <= 1'b1;
                            status <= 2'd1;
                        end else if (irrigation_time == 8'd0) begin
                            done   <= 1'b1;
                            status <= 2'd2;
                        end else begin
                            remaining_s <= req_clamped;
                            presc       <= '0;
                            valve_on    <= 1'b1;
                            state       <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (run_stop) begin
                        valve_on    <= 1'b0;
                        remaining_s <= 8'd0;
                        done        <= 1'b1;
                        status      <= 2'd3;
                        presc       <= '0;
                        cd_cnt      <= '0;
                        state       <= (CD_CYCLES == 0) ? S_IDLE : S_COOLDOWN;
                    end else if (sec_wrap) begin
                        presc       <= '0;
                        remaining_s <= remaining_s - 8'd1;
                        if (remaining_s == 8'd1) begin
                            valve_on <= 1'b0;
                            done     <= 1'b1;
                            status   <= 2'd0;
                            cd_cnt   <= '0;
                            state    <= (CD_CYCLES == 0) ? S_IDLE : S_COOLDOWN;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                S_COOLDOWN: begin
                    if (cd_cnt == CD_MAX) begin
                        state <= S_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IRRIG_USAGE_LOG_EN
    // a second counts only when it fully elapses; the aborted partial second is dropped
    always_ff @(posedge clk) begin
        if (!reset) begin
            total_on_s <= 16'd0;
        end else if (sec_wrap && !run_stop && valve_on && (total_on_s != 16'hFFFF)) begin
            total_on_s <= total_on_s + 16'd1;
        end
    end
`else
    assign total_on_s = 16'd0;
`endif

endmodule

// File: tb/tb_irrigation_valve_ctrl.sv
// tb/tb_irrigation_valve_ctrl.sv - directed and randomized checks of irrigation_valve_ctrl
module tb_irrigation_valve_ctrl;

    localparam int TPS    = 4;
    localparam int MAXON  = 60;
    localparam int MINOFF = 2;
    localparam int CD     = MINOFF * TPS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  irrigation_time = 8'd0;
    logic        rain_present = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready;
    logic        valve_on;
    logic        busy;
    logic [7:0]  remaining_s;
    logic        done;
    logic [1:0]  status;
    logic [15:0] total_on_s;

    int tests = 0;
    int fails = 0;
    int acc_secs = 0;

    irrigation_valve_ctrl #(
        .TICKS_PER_SEC(TPS),
        .MAX_ON_S(MAXON),
        .MIN_OFF_S(MINOFF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irrigation_time(irrigation_time),
        .rain_present(rain_present),
        .start(start),
        .abort(abort),
        .ready(ready),
        .valve_on(valve_on),
        .busy(busy),
        .remaining_s(remaining_s),
        .done(done),
        .status(status),
        .total_on_s(total_on_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_total();
`ifdef IRRIG_USAGE_LOG_EN
        return (acc_secs > 65535) ? 65535 : acc_secs;
`else
        return 0;
`endif
    endfunction

    // Expected behaviour derived from the command rules: skip cases finish at once,
    // runs hold the valve for N*TPS cycles (or until the stop cycle) then cool down CD cycles.
    task automatic do_cmd(input int n, input bit rain0, input int stop_at, input bit stop_rain,
                          input bit stray);
        int nc, on_cyc, exp_status, exp_done_c, exp_ready_c, secs, win, exp_rem;
        int valve_cnt, done_cnt, done_c, ready_c, rem_bad;
        logic [1:0] st_at_done;
        valve_cnt = 0; done_cnt = 0; done_c = -1; ready_c = -1; rem_bad = 0;
        st_at_done = 2'bxx;
        nc = 0;
        if (rain0) begin
            on_cyc = 0; exp_status = 1; exp_done_c = 0; exp_ready_c = 0; secs = 0;
        end else if (n == 0) begin
            on_cyc = 0; exp_status = 2; exp_done_c = 0; exp_ready_c = 0; secs = 0;
        end else begin
            nc          = (n > MAXON) ? MAXON : n;
            on_cyc      = (stop_at > 0) ? stop_at : nc * TPS;
            exp_status  = (stop_at > 0) ? 3 : 0;
            secs        = (stop_at > 0) ? (stop_at - 1) / TPS : nc;
            exp_done_c  = on_cyc;
            exp_ready_c = on_cyc + CD;
        end
        win = exp_ready_c + 4;
        @(negedge clk);
        irrigation_time = n[7:0];
        rain_present    = rain0;
        start           = 1'b1;
        for (int c = 0; c <= win; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (valve_on === 1'b1) valve_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_c     = c;
                st_at_done = status;
            end
            if (ready === 1'b1 && ready_c < 0) ready_c = c;
            exp_rem = (c < on_cyc) ? nc - c / TPS : 0;
            if (remaining_s !== exp_rem[7:0]) rem_bad++;
            if (stop_at > 0 && c == stop_at - 1) begin
                if (stop_rain) rain_present = 1'b1;
                else abort = 1'b1;
            end
            if (stray && on_cyc > 0 && c >= 1 && c <= on_cyc + 6 && (c % 3 == 0)) start = 1'b1;
            if (stray && on_cyc > 0 && c == on_cyc + 2) abort = 1'b1;
        end
        rain_present = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        acc_secs += secs;
        chk($sformatf("valve_cycles n=%0d", n), valve_cnt, on_cyc);
        chk($sformatf("done_count n=%0d", n), done_cnt, 1);
        chk($sformatf("done_cycle n=%0d", n), done_c, exp_done_c);
        chk($sformatf("status n=%0d", n), {30'd0, st_at_done}, exp_status);
        chk($sformatf("ready_cycle n=%0d", n), ready_c, exp_ready_c);
        chk($sformatf("remaining_bad n=%0d", n), rem_bad, 0);
        chk($sformatf("total_on n=%0d", n), {16'd0, total_on_s}, exp_total());
    endtask

    initial begin
        int n, stop_at, mx;
        bit rn, sr, st;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valve", valve_on, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_remaining", remaining_s, 0);
        chk("rst_ready", ready, 1);
        chk("rst_total", total_on_s, 0);

        do_cmd(3, 0, 0, 0, 0);
        do_cmd(45, 1, 0, 0, 0);
        do_cmd(0, 0, 0, 0, 0);
        do_cmd(100, 0, 0, 0, 0);
        do_cmd(10, 0, 6, 0, 0);
        do_cmd(10, 0, 6, 1, 0);
        do_cmd(4, 0, 0, 0, 1);

        // abort alongside start in IDLE wins
        @(negedge clk);
        irrigation_time = 8'd3;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_prio_ready", ready, 1);
        chk("abort_prio_valve", valve_on, 0);
        chk("abort_prio_done", done, 0);

        // reset in the middle of a run
        @(negedge clk);
        irrigation_time = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_reset_valve", valve_on, 1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valve", valve_on, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_remaining", remaining_s, 0);
        chk("midrst_status", status, 0);
        reset = 1'b1;
        acc_secs = 0;
        begin
            int seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (done === 1'b1 || valve_on === 1'b1) seen++;
            end
            chk("midrst_quiet", seen, 0);
        end

        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) n = 0;
            rn = ($urandom_range(0, 5) == 0);
            sr = $urandom_range(0, 1);
            st = $urandom_range(0, 1);
            stop_at = 0;
            if (!rn && n > 0 && $urandom_range(0, 2) == 0) begin
                mx = ((n > MAXON) ? MAXON : n) * TPS;
                if (mx > 1) begin
                    stop_at = $urandom_range(1, mx - 1);
                    if (stop_at % TPS == 0) stop_at = stop_at - 1;
                end
            end
            do_cmd(n, rn, stop_at, sr, st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
